// File: rtl/evt2_byte_packer.sv
// Packs a UART byte stream into 32-bit little-endian EVT2 words behind a small
// first-word-fall-through buffer, with an inter-byte timeout and overflow drop counting.
module evt2_byte_packer #(
   parameter int CLK_FREQ_HZ     = 12_000_000,
   parameter int BYTE_TIMEOUT_US = 100,
   parameter int OUT_DEPTH       = 4,
   parameter int STAT_BITS       = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   rx_byte,
   input  logic                         rx_valid,
   input  logic                         flush,
   output logic [31:0]                  word_out,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic [1:0]                   byte_phase,
   output logic [$clog2(OUT_DEPTH):0]   buf_level,
   output logic [STAT_BITS-1:0]         drop_count,
   output logic [STAT_BITS-1:0]         timeout_count
);

   localparam int TO_CYC = CLK_FREQ_HZ / 1_000_000 * BYTE_TIMEOUT_US;
   localparam int TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
   localparam int AW     = $clog2(OUT_DEPTH);
   localparam int LW     = AW + 1;
   localparam logic [TW-1:0]        TO_LAST  = TW'(TO_CYC - 1);
   localparam logic [LW-1:0]        LVL_FULL = LW'(OUT_DEPTH);
   localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t                 state_r;
   logic [1:0]             phase_r;
   logic [23:0]            part_r;
   logic [TW-1:0]          to_cnt_r;
   logic [31:0]            mem_r [OUT_DEPTH];
   logic [AW-1:0]          rd_ptr_r;
   logic [AW-1:0]          wr_ptr_r;
   logic [LW-1:0]          count_r;
   logic [31:0]            word_out_r;
   logic                   word_valid_r;
   logic [STAT_BITS-1:0]   drop_r;
   logic [STAT_BITS-1:0]   tout_r;

   logic                   timeout_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   full_s;
   logic                   push_ok_s;
   logic                   drop_s;
   logic [31:0]            new_word_s;
   logic [AW-1:0]          rd_nxt_s;
   logic [LW-1:0]          count_nxt_s;
   logic [31:0]            head_nxt_s;

   // Next-state decode for the assembler and the output buffer
   always_comb begin
      timeout_s   = (state_r == COLLECT) && !rx_valid && !flush && (to_cnt_r == TO_LAST);
      push_s      = rx_valid && !flush && (phase_r == 2'd3);
      new_word_s  = {rx_byte, part_r};
      pop_s       = word_valid_r && word_ready && !flush;
      full_s      = (count_r == LVL_FULL);
      push_ok_s   = push_s && (!full_s || pop_s);
      drop_s      = push_s && full_s && !pop_s;
      rd_nxt_s    = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      case ({push_ok_s, pop_s})
         2'b10:   count_nxt_s = count_r + LW'(1);
         2'b01:   count_nxt_s = count_r - LW'(1);
         default: count_nxt_s = count_r;
      endcase
      // A word pushed into a buffer that is (or becomes) empty is the next head
      if (push_ok_s && (wr_ptr_r == rd_nxt_s)) begin
         head_nxt_s = new_word_s;
      end else begin
         head_nxt_s = mem_r[rd_nxt_s];
      end
   end

   // Buffer storage; no reset needed since pointers and count gate every read
   always_ff @(posedge clk) begin
      if (!rst && push_ok_s) begin
         mem_r[wr_ptr_r] <= new_word_s;
      end
   end

   // Assembler FSM, timeout, buffer pointers, registered outputs and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         phase_r      <= 2'd0;
         part_r       <= 24'd0;
         to_cnt_r     <= '0;
         rd_ptr_r     <= '0;
         wr_ptr_r     <= '0;
         count_r      <= '0;
         word_out_r   <= 32'd0;
         word_valid_r <= 1'b0;
         drop_r       <= '0;
         tout_r       <= '0;
      end else if (flush) begin
         state_r      <= IDLE;
         phase_r      <= 2'd0;
         part_r       <= 24'd0;
         to_cnt_r     <= '0;
         rd_ptr_r     <= '0;
         wr_ptr_r     <= '0;
         count_r      <= '0;
         word_out_r   <= 32'd0;
         word_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               to_cnt_r <= '0;
               if (rx_valid) begin
                  state_r      <= COLLECT;
                  phase_r      <= 2'd1;
                  part_r       <= {16'd0, rx_byte};
               end
            end
            COLLECT: begin
               if (rx_valid) begin
                  to_cnt_r <= '0;
                  if (phase_r == 2'd3) begin
                     state_r <= IDLE;
                     phase_r <= 2'd0;
                     part_r  <= 24'd0;
                  end else begin
                     phase_r <= phase_r + 2'd1;
                     case (phase_r)
                        2'd1:    part_r[15:8]  <= rx_byte;
                        2'd2:    part_r[23:16] <= rx_byte;
                        default: part_r        <= part_r;
                     endcase
                  end
               end else if (timeout_s) begin
                  state_r  <= IDLE;
                  phase_r  <= 2'd0;
                  part_r   <= 24'd0;
                  to_cnt_r <= '0;
               end else begin
                  to_cnt_r <= to_cnt_r + TW'(1);
               end
            end
            default: begin
               state_r  <= IDLE;
               phase_r  <= 2'd0;
               part_r   <= 24'd0;
               to_cnt_r <= '0;
            end
         endcase

         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r     <= rd_nxt_s;
         count_r      <= count_nxt_s;
         word_valid_r <= (count_nxt_s != '0);
         // Hold the presented word steady while nothing new reaches the head
         if (count_nxt_s != '0) begin
            word_out_r <= head_nxt_s;
         end

         if (drop_s && (drop_r != STAT_MAX)) begin
            drop_r <= drop_r + STAT_BITS'(1);
         end
         if (timeout_s && (tout_r != STAT_MAX)) begin
            tout_r <= tout_r + STAT_BITS'(1);
         end
      end
   end

   assign word_out      = word_out_r;
   assign word_valid    = word_valid_r;
   assign byte_phase    = phase_r;
   assign buf_level     = count_r;
   assign drop_count    = drop_r;
   assign timeout_count = tout_r;

endmodule
